// File: rtl/beat_gen_if.sv
// Bus bundle for beat_gen: tap-period input side and beat/LED/bar outputs.
// The master drives the time pulse and period; the slave (beat_gen) drives the beat indications.
interface beat_gen_if #(
    parameter int PER_WIDTH = 17
);
    logic                 tp_i;
    logic [PER_WIDTH-1:0] per_i;
    logic                 per_valid_i;
    logic                 beat_o;
    logic                 downbeat_o;
    logic                 led_o;
    logic [3:0]           bar_pos_o;
    logic                 running_o;

    modport master (
        output tp_i, per_i, per_valid_i,
        input  beat_o, downbeat_o, led_o, bar_pos_o, running_o
    );

    modport slave (
        input  tp_i, per_i, per_valid_i,
        output beat_o, downbeat_o, led_o, bar_pos_o, running_o
    );
endinterface

// File: rtl/beat_gen.sv
// Tempo playback: regenerates a periodic beat from a measured tap period in tp units,
// with a stretched LED pulse and bar-position / downbeat indication.
module beat_gen #(
    parameter int PER_MAX       = 62600,
    parameter int PER_WIDTH     = 17,
    parameter int PER_MIN       = 16,
    parameter int PULSE_TP      = 8192,
    parameter int BEATS_PER_BAR = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    beat_gen_if.slave   bus
);
    localparam int LED_W = $clog2(PULSE_TP + 1);
    localparam logic [PER_WIDTH-1:0] PER_MIN_W = PER_WIDTH'(PER_MIN);
    localparam logic [PER_WIDTH-1:0] PER_MAX_W = PER_WIDTH'(PER_MAX);
    localparam logic [LED_W-1:0]     PULSE_W   = LED_W'(PULSE_TP);
    localparam logic [3:0]           BAR_LAST  = 4'(BEATS_PER_BAR - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_reg, state_next;
    logic [PER_WIDTH-1:0] per_reg, per_next;
    logic [PER_WIDTH-1:0] phase_reg, phase_next;
    logic [LED_W-1:0]     led_cnt_reg, led_cnt_next;
    logic [3:0]           bar_pos_reg, bar_pos_next;
    logic                 led_reg, led_next;
    logic                 beat_reg, beat_next;
    logic                 downbeat_reg, downbeat_next;

    logic per_ok, accept, reject, emit;

    always_comb begin
        state_next    = state_reg;
        per_next      = per_reg;
        phase_next    = phase_reg;
        led_cnt_next  = led_cnt_reg;
        bar_pos_next  = bar_pos_reg;
        led_next      = led_reg;
        emit          = 1'b0;
        per_ok        = (bus.per_i >= PER_MIN_W) && (bus.per_i < PER_MAX_W);
        accept        = bus.per_valid_i && per_ok;
        reject        = bus.per_valid_i && !per_ok;

        case (state_reg)
            IDLE: begin
                phase_next = '0;
                if (accept) begin
                    per_next     = bus.per_i;
                    bar_pos_next = '0;
                    emit         = 1'b1;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    // A tap realigns the beat to itself; a coincident tp is not counted.
                    per_next     = bus.per_i;
                    phase_next   = '0;
                    bar_pos_next = '0;
                    emit         = 1'b1;
                end else if (reject) begin
                    state_next   = IDLE;
                    per_next     = '0;
                    phase_next   = '0;
                    bar_pos_next = '0;
                end else if (bus.tp_i) begin
                    if (phase_reg + 1'b1 == per_reg) begin
                        phase_next   = '0;
                        bar_pos_next = (bar_pos_reg == BAR_LAST) ? 4'd0 : bar_pos_reg + 4'd1;
                        emit         = 1'b1;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A beat restarts the stretch, so the tp in a beat cycle never advances led_cnt.
        if (emit) begin
            led_next     = 1'b1;
            led_cnt_next = '0;
        end else if (reject) begin
            led_next     = 1'b0;
            led_cnt_next = '0;
        end else if (bus.tp_i && led_reg) begin
            led_cnt_next = led_cnt_reg + 1'b1;
            if (led_cnt_reg + 1'b1 == PULSE_W) begin
                led_next = 1'b0;
            end
        end

        beat_next     = emit;
        downbeat_next = emit && (bar_pos_next == 4'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            per_reg      <= '0;
            phase_reg    <= '0;
            led_cnt_reg  <= '0;
            bar_pos_reg  <= '0;
            led_reg      <= 1'b0;
            beat_reg     <= 1'b0;
            downbeat_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            per_reg      <= per_next;
            phase_reg    <= phase_next;
            led_cnt_reg  <= led_cnt_next;
            bar_pos_reg  <= bar_pos_next;
            led_reg      <= led_next;
            beat_reg     <= beat_next;
            downbeat_reg <= downbeat_next;
        end
    end

    assign bus.beat_o     = beat_reg;
    assign bus.downbeat_o = downbeat_reg;
    assign bus.led_o      = led_reg;
    assign bus.bar_pos_o  = bar_pos_reg;
    assign bus.running_o  = (state_reg == RUN);
endmodule

// File: doc/beat_gen.md
# beat_gen

Tempo playback block: the inverse of the button period counter. It accepts a measured tap period, expressed in time-pulse (`tp_i`) units, and regenerates a periodic beat at that tempo. It drives a one-cycle beat strobe, a stretched LED pulse and a bar-position/downbeat indication. It sits downstream of the period counter, sharing its `tp_i` time base, and feeds the LED and metronome outputs of the TapTempo top level.

## Interface
- `PER_MAX`, 62600, saturation value of the incoming period; receiving it means no tempo and stops playback
- `PER_WIDTH`, 17, width of the period bus, matching the period counter output
- `PER_MIN`, 16, smallest accepted period in tp units; smaller values stop playback
- `PULSE_TP`, 8192, LED on-time in tp units
- `BEATS_PER_BAR`, 4, beats per bar, range 2..16
- `clk_i` input 1 system clock; all logic is on the rising edge
- `rst_i` input 1 reset, synchronous and active-high
- `tp_i` input 1 time pulse, one cycle wide, the same strobe used by the period counter
- `per_i` input PER_WIDTH new period in tp units; sampled only while `per_valid_i`=1
- `per_valid_i` input 1 one-cycle strobe qualifying `per_i`
- `beat_o` output 1 one-cycle strobe at each beat
- `downbeat_o` output 1 one-cycle strobe, coincident with `beat_o` when bar position is 0
- `led_o` output 1 stretched beat indicator
- `bar_pos_o` output 4 index of the current beat within the bar, 0..BEATS_PER_BAR-1
- `running_o` output 1 high while in the RUN state

## Operation
- Registers:
  - `per_r` (PER_WIDTH), latched period
  - `phase` (PER_WIDTH), tp count since the last beat
  - `led_cnt` (clog2(PULSE_TP+1)), LED on-time counter
  - `bar_pos` (4), position within the bar
  - `state`, one of IDLE or RUN
- Period classification on a `per_valid_i` cycle:
  - Accepted if PER_MIN <= `per_i` < PER_MAX.
  - Rejected otherwise, including `per_i`=0 and `per_i`>=PER_MAX.
- IDLE:
  - `phase` is held at 0; no beats are produced.
  - On an accepted period: `per_r`<=`per_i`, `phase`<=0, `bar_pos`<=0, emit a beat, go to RUN.
  - A rejected period leaves the block in IDLE.
- RUN:
  - On `tp_i`, if `phase`+1 == `per_r`: emit a beat, `phase`<=0, `bar_pos`<=(`bar_pos`+1) mod BEATS_PER_BAR.
  - On `tp_i` otherwise: `phase`<=`phase`+1.
  - On an accepted period: resynchronise. Load `per_r`, set `phase`<=0 and `bar_pos`<=0, and emit a beat immediately. Tapping therefore realigns the phase to the tap.
  - On a rejected period: go to IDLE. `led_o`, `bar_pos_o` and `per_r` are cleared.
- Emitting a beat means:
  - `beat_o`=1 for exactly one cycle.
  - `downbeat_o`=1 in the same cycle if the new `bar_pos` is 0.
  - `led_o`<=1 and `led_cnt`<=0.
- LED stretch:
  - While `led_o`=1, each `tp_i` increments `led_cnt`.
  - `led_o` clears on the `tp_i` that brings `led_cnt` to PULSE_TP.
  - A new beat restarts the stretch, so `led_o` stays high continuously if the period is at most PULSE_TP.
- Simultaneous events:
  - `per_valid_i` together with `tp_i`: `per_valid_i` wins and that `tp_i` is not counted by `phase`.
  - The same `tp_i` still advances `led_cnt`, but only if no beat is emitted in that cycle.
- Arithmetic and width rules:
  - `phase` never exceeds `per_r`-1, so it cannot wrap.
  - `bar_pos` is compared against BEATS_PER_BAR-1 and is never computed by modulo hardware.
  - A `per_i` wider than PER_MAX cannot occur legally; the rejection rule covers it anyway.

## Timing
- Reset: every output is 0 and the state is IDLE. `per_r`, `phase`, `led_cnt` and `bar_pos` are all 0.
- Reset is synchronous and wins over every other input in the same cycle. Asserting it mid-RUN drops all outputs on the next edge.
- All outputs are registered.
- `beat_o` rises one clock after the qualifying `per_valid_i` or `tp_i` edge.
- `running_o` rises in the same cycle as the first `beat_o`.
- Beat spacing in RUN is exactly `per_r` `tp_i` pulses. Spacing in clocks depends on the `tp_i` cadence.
- `per_valid_i` is treated as a one-cycle strobe. Back-to-back strobes are each processed, and the last one wins.

## Test plan
- Reset, then `per_valid_i` with `per_i`=100, `tp_i` every 4 clocks:
  - beat, downbeat and running rise 1 clock after valid.
  - Next beats arrive every 100 `tp_i`.
  - `bar_pos_o` goes 0,1,2,3,0, with a downbeat every 4th beat.
- With `per_i`=100 running, reissue `per_valid_i` at `phase`=37:
  - Immediate beat with downbeat, `bar_pos_o`=0.
  - Next beat exactly 100 `tp_i` later.
- `per_i`=62600, then `per_i`=0, then `per_i`=15, each while RUN:
  - Each one sends the block to IDLE: `running_o`=0, `led_o`=0.
  - No further `beat_o`.
- PULSE_TP=8, `per_i`=20: `led_o` is high for 8 `tp_i` after each beat, then low for 12.
- PULSE_TP=8, `per_i`=20, switch to `per_i`=16 (≥PER_MIN): LED cycle becomes 8 high, 8 low.
- `per_valid_i` coincident with `tp_i` at `phase`=`per_r`-1:
  - Exactly one beat is emitted, with `phase`=0 afterwards.
  - Assert `rst_i` mid-LED: all outputs are 0 on the next clock.
